mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM for the single-memory-port MIPS-subset CPU.
- Sequences every instruction through IF/ID/EXE/MEM/WB and drives all datapath enables, including the PC register's write enable and next-PC select.
- Sits between the instruction register (opcode source) and the datapath (PC, IR, register file, ALU, data memory).

Parameters:
- None. Opcode, state and ALUOp encodings are package constants.

Ports:
- CLK  in  1  system clock; FSM state register updates on posedge.
- Reset  in  1  asynchronous, active-low; 0 forces state to IF.
- OpCode  in  6  IR[31:26]; stable from ID onward.
- Zero  in  1  ALU result == 0.
- Sign  in  1  ALU result[31].
- PCWre  out  1  PC write enable; PC samples on negedge CLK.
- PCSrc  out  2  next PC: 00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.
- IRWre  out  1  instruction register write enable.
- InsMemRW  out  1  1 = instruction memory read.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- RegWre  out  1  register file write enable.
- RegDst  out  2  00 $31, 01 rt, 10 rd.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB bus.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- State  out  4  current state, for debug.

Behaviour:
- Opcodes:
  - R/ALU group: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slt 100110, slti 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bne 110101, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - halt 111111.
  - Any other opcode is illegal and treated as a NOP.
- States: IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_BR 0100, EXE_LS 0101, MEM 0110, WB_LD 0111, HALT 1000.
- Transitions:
  - IF -> ID.
  - ID -> IF for j, jr, jal and illegal opcodes.
  - ID -> HALT for halt.
  - ID -> EXE_BR for branches; ID -> EXE_LS for lw/sw; ID -> EXE_AL for the ALU group.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM; MEM -> IF for sw, MEM -> WB_LD for lw; WB_LD -> IF.
  - HALT is absorbing until Reset.
- Cycle counts: ALU group 4, lw 5, sw 4, branch 3, jump/NOP 2.
- Outputs are combinational from state and OpCode. Any output not listed for a state is 0.
- IF: InsMemRW=1, IRWre=1.
- ID:
  - j: PCWre=1, PCSrc=11.
  - jr: PCWre=1, PCSrc=10.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - illegal: PCWre=1, PCSrc=00.
  - halt: nothing asserted.
- EXE_AL / WB_AL / EXE_LS / MEM / WB_LD datapath selects:
  - ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
  - ALUSrcA=1 for sll.
  - ExtSel=0 for andi, ori, xori; ExtSel=1 otherwise.
  - ALUOp per mnemonic; lw/sw use add.
- WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 for R-type or 01 for immediate forms, PCWre=1, PCSrc=00.
- EXE_BR: ALUOp=001, PCWre=1.
  - PCSrc=01 if taken, else 00.
  - beq is taken on Zero=1, bne on Zero=0, bltz on Sign=1.
- MEM:
  - lw: mRD=1.
  - sw: mWR=1, PCWre=1, PCSrc=00.
- WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1, PCSrc=00.
- HALT: all outputs 0; PC and IR frozen.
- Invariants:
  - Exactly one PCWre pulse per completed instruction.
  - PCWre is never active in IF.
  - PC updates at the negedge within the final state of each instruction.
- Reset:
  - While Reset=0, state=IF and all outputs are 0, including IRWre and InsMemRW.
  - Assertion mid-instruction aborts immediately with no further writes.
  - After release, the first posedge stays in IF with IRWre=1.
- Zero and Sign are don't-care outside EXE_BR.

Decomposition:
- Package mc_ctrl_pkg: opcode localparams, state encoding, ALUOp codes, PCSrc and RegDst codes.
- One sub-module, mc_ctrl_decode: purely combinational (state, OpCode, Zero, Sign) -> control word.
- The top module holds only the state register and next-state logic.

Test Plan:
- Reset low for 3 cycles, then release, OpCode=add -> State sequence 0,1,2,3,0; PCWre high only in WB_AL; RegDst=10; RegWre=1 in WB_AL only.
- lw (110001) -> states 0,1,5,6,7,0; mRD=1 in MEM and WB_LD; DBDataSrc=1, RegWre=1 in WB_LD.
- sw (110000) -> mWR=1 and PCWre=1 in MEM; returns to IF; no RegWre anywhere.
- beq with Zero=1 -> PCSrc=01; beq with Zero=0 -> PCSrc=00; bltz with Sign=1 -> PCSrc=01; each takes 3 cycles.
- jal (111010) in ID -> PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, next state IF; illegal opcode 101010 -> PCSrc=00 NOP.
- halt (111111) -> State=1000 for 20 cycles with all outputs 0; Reset pulse while in EXE_LS or HALT -> immediate IF, outputs 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes, FSM states,
// ALU operation codes, PC and register-destination selects, and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StIf    = 4'b0000,
    StId    = 4'b0001,
    StExeAl = 4'b0010,
    StWbAl  = 4'b0011,
    StExeBr = 4'b0100,
    StExeLs = 4'b0101,
    StMem   = 4'b0110,
    StWbLd  = 4'b0111,
    StHalt  = 4'b1000
  } state_e;

  // ALU / R-type group
  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAddiu = 6'b000010;
  localparam logic [5:0] OpAnd   = 6'b010000;
  localparam logic [5:0] OpAndi  = 6'b010001;
  localparam logic [5:0] OpOri   = 6'b010010;
  localparam logic [5:0] OpXori  = 6'b010011;
  localparam logic [5:0] OpSll   = 6'b011000;
  localparam logic [5:0] OpSlt   = 6'b100110;
  localparam logic [5:0] OpSlti  = 6'b100111;
  // Memory
  localparam logic [5:0] OpSw    = 6'b110000;
  localparam logic [5:0] OpLw    = 6'b110001;
  // Branch
  localparam logic [5:0] OpBeq   = 6'b110100;
  localparam logic [5:0] OpBne   = 6'b110101;
  localparam logic [5:0] OpBltz  = 6'b110110;
  // Jump
  localparam logic [5:0] OpJ     = 6'b111000;
  localparam logic [5:0] OpJr    = 6'b111001;
  localparam logic [5:0] OpJal   = 6'b111010;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSll = 3'b110;

  localparam logic [1:0] PcSrcNext   = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcReg    = 2'b10;
  localparam logic [1:0] PcSrcJump   = 2'b11;

  localparam logic [1:0] RegDstRa = 2'b00;
  localparam logic [1:0] RegDstRt = 2'b01;
  localparam logic [1:0] RegDstRd = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
  } ctrl_t;

  function automatic logic is_alu_group(logic [5:0] op);
    case (op)
      OpAdd, OpSub, OpAddiu, OpAnd, OpAndi,
      OpOri, OpXori, OpSll, OpSlt, OpSlti: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // ALU-group forms whose destination is rt and whose B operand is the immediate
  function automatic logic is_imm_form(logic [5:0] op);
    case (op)
      OpAddiu, OpAndi, OpOri, OpXori, OpSlti: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

  function automatic logic is_branch(logic [5:0] op);
    return (op == OpBeq) || (op == OpBne) || (op == OpBltz);
  endfunction

  function automatic logic is_jump(logic [5:0] op);
    return (op == OpJ) || (op == OpJr) || (op == OpJal);
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return is_alu_group(op) || is_mem(op) || is_branch(op) || is_jump(op) || (op == OpHalt);
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic is_zero_ext(logic [5:0] op);
    return (op == OpAndi) || (op == OpOri) || (op == OpXori);
  endfunction

  function automatic logic [2:0] alu_op_of(logic [5:0] op);
    case (op)
      OpSub:          return AluSub;
      OpAnd, OpAndi:  return AluAnd;
      OpOri:          return AluOr;
      OpXori:         return AluXor;
      OpSlt, OpSlti:  return AluSlt;
      OpSll:          return AluSll;
      default:        return AluAdd;  // add, addiu, lw, sw
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from FSM state, opcode and ALU flags.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       sign_i,
  output ctrl_t      ctrl_o
);

  logic branch_taken;

  // Branch condition from the ALU flags of the rs - rt comparison
  always_comb begin
    branch_taken = 1'b0;
    case (opcode_i)
      OpBeq:   branch_taken = zero_i;
      OpBne:   branch_taken = ~zero_i;
      OpBltz:  branch_taken = sign_i;
      default: branch_taken = 1'b0;
    endcase
  end

  // Control word: datapath selects held across the ALU/LS path, then per-state strobes
  always_comb begin
    ctrl_o = '0;

    if (state_i inside {StExeAl, StWbAl, StExeLs, StMem, StWbLd}) begin
      ctrl_o.alu_src_b = is_imm_form(opcode_i) | is_mem(opcode_i);
      ctrl_o.alu_src_a = (opcode_i == OpSll);
      ctrl_o.ext_sel   = ~is_zero_ext(opcode_i);
      ctrl_o.alu_op    = alu_op_of(opcode_i);
    end

    case (state_i)
      StIf: begin
        ctrl_o.ins_mem_rw = 1'b1;
        ctrl_o.ir_wre     = 1'b1;
      end
      StId: begin
        // Jumps and illegal opcodes retire here; everything else continues
        if (opcode_i == OpJ) begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PcSrcJump;
        end else if (opcode_i == OpJr) begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PcSrcReg;
        end else if (opcode_i == OpJal) begin
          ctrl_o.pc_wre       = 1'b1;
          ctrl_o.pc_src       = PcSrcJump;
          ctrl_o.reg_wre      = 1'b1;
          ctrl_o.reg_dst      = RegDstRa;
          ctrl_o.wr_reg_d_src = 1'b0;
        end else if (!is_legal(opcode_i)) begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PcSrcNext;
        end
      end
      StWbAl: begin
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.db_data_src  = 1'b0;
        ctrl_o.reg_dst      = is_imm_form(opcode_i) ? RegDstRt : RegDstRd;
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.pc_src       = PcSrcNext;
      end
      StExeBr: begin
        ctrl_o.alu_op = AluSub;
        ctrl_o.pc_wre = 1'b1;
        ctrl_o.pc_src = branch_taken ? PcSrcBranch : PcSrcNext;
      end
      StMem: begin
        if (opcode_i == OpLw) begin
          ctrl_o.m_rd = 1'b1;
        end else begin
          ctrl_o.m_wr   = 1'b1;
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PcSrcNext;
        end
      end
      StWbLd: begin
        ctrl_o.m_rd         = 1'b1;
        ctrl_o.db_data_src  = 1'b1;
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.reg_dst      = RegDstRt;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.pc_src       = PcSrcNext;
      end
      default: ;  // StExeAl, StExeLs: selects only; StHalt: all zero
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: state register, next-state logic and the decode instance.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       Sign,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [3:0] State
);

  state_e state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;

  // State register; reset parks the machine in IF
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing through the instruction phases
  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (OpCode == OpHalt)          state_d = StHalt;
        else if (is_branch(OpCode))    state_d = StExeBr;
        else if (is_mem(OpCode))       state_d = StExeLs;
        else if (is_alu_group(OpCode)) state_d = StExeAl;
        else                           state_d = StIf;
      end
      StExeAl: state_d = StWbAl;
      StWbAl:  state_d = StIf;
      StExeBr: state_d = StIf;
      StExeLs: state_d = StMem;
      StMem:   state_d = (OpCode == OpLw) ? StWbLd : StIf;
      StWbLd:  state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (OpCode),
    .zero_i   (Zero),
    .sign_i   (Sign),
    .ctrl_o   (ctrl_raw)
  );

  // Outputs: decoded control word, forced quiet while reset is held
  always_comb begin
    ctrl = Reset ? ctrl_raw : '0;
  end

  assign PCWre     = ctrl.pc_wre;
  assign PCSrc     = ctrl.pc_src;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ExtSel    = ctrl.ext_sel;
  assign RegWre    = ctrl.reg_wre;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign DBDataSrc = ctrl.db_data_src;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit.
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] OpCode;
  logic       Zero, Sign;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  // {PCWre,PCSrc,IRWre,InsMemRW,ALUSrcA,ALUSrcB,ALUOp,ExtSel,RegWre,RegDst,WrRegDSrc,DBDataSrc,mRD,mWR}
  logic [17:0] outs;
  assign outs = {PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre,
                 RegDst, WrRegDSrc, DBDataSrc, mRD, mWR};

  localparam logic [17:0] OutZero = 18'b0;
  localparam logic [17:0] OutIf   = 18'b0_00_1_1_0_0_000_0_0_00_0_0_0_0;

  mc_control_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .OpCode    (OpCode),
    .Zero      (Zero),
    .Sign      (Sign),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .State     (State)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset  = 1'b0;
    OpCode = 6'b000000;
    Zero   = 1'b0;
    Sign   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (State !== 4'd0 || outs !== OutZero) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: State=%0d outs=%b, want State=0 outs=%b",
                 i, State, outs, OutZero);
      end
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0 || outs !== OutIf) begin
      n_fail++;
      $display("FAIL reset_release: State=%0d outs=%b, want State=0 outs=%b", State, outs, OutIf);
    end
  endtask

  task automatic test_alu();
    logic [5:0]  ops [4] = '{6'b000000, 6'b010010, 6'b011000, 6'b100111};
    logic [17:0] exe [4] = '{18'b0_00_0_0_0_0_000_1_0_00_0_0_0_0,
                             18'b0_00_0_0_0_1_011_0_0_00_0_0_0_0,
                             18'b0_00_0_0_1_0_110_1_0_00_0_0_0_0,
                             18'b0_00_0_0_0_1_101_1_0_00_0_0_0_0};
    logic [17:0] wb  [4] = '{18'b1_00_0_0_0_0_000_1_1_10_1_0_0_0,
                             18'b1_00_0_0_0_1_011_0_1_01_1_0_0_0,
                             18'b1_00_0_0_1_0_110_1_1_10_1_0_0_0,
                             18'b1_00_0_0_0_1_101_1_1_01_1_0_0_0};
    logic [3:0]  es  [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [17:0] eo  [5];
    for (int k = 0; k < 4; k++) begin
      OpCode = ops[k];
      eo = '{OutIf, OutZero, exe[k], wb[k], OutIf};
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (State !== es[i] || outs !== eo[i]) begin
          n_fail++;
          $display("FAIL alu op=%b cyc%0d: State=%0d outs=%b, want State=%0d outs=%b",
                   ops[k], i, State, outs, es[i], eo[i]);
        end
        if (i < 4) step();
      end
    end
  endtask

  task automatic test_load();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd0};
    logic [17:0] eo [6] = '{OutIf, OutZero,
                            18'b0_00_0_0_0_1_000_1_0_00_0_0_0_0,
                            18'b0_00_0_0_0_1_000_1_0_00_0_0_1_0,
                            18'b1_00_0_0_0_1_000_1_1_01_1_1_1_0,
                            OutIf};
    OpCode = 6'b110001;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (State !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL lw cyc%0d: State=%0d outs=%b, want State=%0d outs=%b",
                 i, State, outs, es[i], eo[i]);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_store();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd0};
    logic [17:0] eo [5] = '{OutIf, OutZero,
                            18'b0_00_0_0_0_1_000_1_0_00_0_0_0_0,
                            18'b1_00_0_0_0_1_000_1_0_00_0_0_0_1,
                            OutIf};
    OpCode = 6'b110000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (State !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL sw cyc%0d: State=%0d outs=%b, want State=%0d outs=%b",
                 i, State, outs, es[i], eo[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [6] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101, 6'b110110, 6'b110110};
    logic        zs  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ss  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [17:0] br  [6] = '{18'b1_01_0_0_0_0_001_0_0_00_0_0_0_0,
                             18'b1_00_0_0_0_0_001_0_0_00_0_0_0_0,
                             18'b1_01_0_0_0_0_001_0_0_00_0_0_0_0,
                             18'b1_00_0_0_0_0_001_0_0_00_0_0_0_0,
                             18'b1_01_0_0_0_0_001_0_0_00_0_0_0_0,
                             18'b1_00_0_0_0_0_001_0_0_00_0_0_0_0};
    logic [3:0]  es  [4] = '{4'd0, 4'd1, 4'd4, 4'd0};
    logic [17:0] eo  [4];
    for (int k = 0; k < 6; k++) begin
      OpCode = ops[k];
      Zero   = zs[k];
      Sign   = ss[k];
      eo = '{OutIf, OutZero, br[k], OutIf};
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (State !== es[i] || outs !== eo[i]) begin
          n_fail++;
          $display("FAIL branch#%0d op=%b Z=%b S=%b cyc%0d: State=%0d outs=%b, want State=%0d outs=%b",
                   k, ops[k], zs[k], ss[k], i, State, outs, es[i], eo[i]);
        end
        if (i < 3) step();
      end
    end
    Zero = 1'b0;
    Sign = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0]  ops [4] = '{6'b111000, 6'b111001, 6'b111010, 6'b101010};
    logic [17:0] idv [4] = '{18'b1_11_0_0_0_0_000_0_0_00_0_0_0_0,
                             18'b1_10_0_0_0_0_000_0_0_00_0_0_0_0,
                             18'b1_11_0_0_0_0_000_0_1_00_0_0_0_0,
                             18'b1_00_0_0_0_0_000_0_0_00_0_0_0_0};
    logic [3:0]  es  [3] = '{4'd0, 4'd1, 4'd0};
    logic [17:0] eo  [3];
    for (int k = 0; k < 4; k++) begin
      OpCode = ops[k];
      eo = '{OutIf, idv[k], OutIf};
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (State !== es[i] || outs !== eo[i]) begin
          n_fail++;
          $display("FAIL jump op=%b cyc%0d: State=%0d outs=%b, want State=%0d outs=%b",
                   ops[k], i, State, outs, es[i], eo[i]);
        end
        if (i < 2) step();
      end
    end
  endtask

  task automatic test_reset_mid();
    OpCode = 6'b110001;
    step();
    step();
    n_checks++;
    if (State !== 4'd5) begin
      n_fail++;
      $display("FAIL rst_mid_pre: State=%0d, want State=5", State);
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd0 || outs !== OutZero) begin
      n_fail++;
      $display("FAIL rst_mid_assert: State=%0d outs=%b, want State=0 outs=%b",
               State, outs, OutZero);
    end
    step();
    n_checks++;
    if (State !== 4'd0 || outs !== OutZero) begin
      n_fail++;
      $display("FAIL rst_mid_hold: State=%0d outs=%b, want State=0 outs=%b",
               State, outs, OutZero);
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0 || outs !== OutIf) begin
      n_fail++;
      $display("FAIL rst_mid_release: State=%0d outs=%b, want State=0 outs=%b",
               State, outs, OutIf);
    end
  endtask

  task automatic test_halt();
    OpCode = 6'b111111;
    step();
    n_checks++;
    if (State !== 4'd1 || outs !== OutZero) begin
      n_fail++;
      $display("FAIL halt_id: State=%0d outs=%b, want State=1 outs=%b", State, outs, OutZero);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (State !== 4'd8 || outs !== OutZero) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: State=%0d outs=%b, want State=8 outs=%b",
                 i, State, outs, OutZero);
      end
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd0 || outs !== OutZero) begin
      n_fail++;
      $display("FAIL halt_reset: State=%0d outs=%b, want State=0 outs=%b", State, outs, OutZero);
    end
    Reset = 1'b1;
    #1;
    OpCode = 6'b000000;
    step();
    n_checks++;
    if (State !== 4'd1) begin
      n_fail++;
      $display("FAIL halt_resume: State=%0d, want State=1", State);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_reset_mid();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
